// File: rtl/sa_pkg.sv
// Shared types for the skewed systolic MAC: tile FSM states and the flush length.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } sa_state_e;

    // Cycles needed for the last beat to travel from the array corner to PE (ROWS-1, COLS-1)
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// Output-stationary processing element: forwards a right and b down, accumulates a*b.
// Define SA_SATURATE_EN to clamp the accumulator instead of wrapping.
module sa_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              sgn,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);

    logic [DATA_W-1:0]          a_q, a_d, b_q, b_d;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic signed [2*DATA_W-1:0] prod_sgn;
    logic [2*DATA_W-1:0]        prod_uns;
    logic [ACC_W-1:0]           prod, base, acc_next;
`ifdef SA_SATURATE_EN
    logic [ACC_W:0]             sum_ext;
`endif

    // Product extension, accumulate (wrap or clamp) and pass-through next state
    always_comb begin
        prod_sgn = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
        prod_uns = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
        prod     = sgn ? ACC_W'(prod_sgn) : ACC_W'(prod_uns);
        base     = clr ? '0 : acc_q;
`ifdef SA_SATURATE_EN
        if (sgn) begin
            sum_ext = {base[ACC_W-1], base} + {prod[ACC_W-1], prod};
            if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
                acc_next = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                acc_next = sum_ext[ACC_W-1:0];
            end
        end else begin
            sum_ext  = {1'b0, base} + {1'b0, prod};
            acc_next = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        end
`else
        acc_next = base + prod;
`endif
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (en) begin
            a_d   = a_i;
            b_d   = b_i;
            acc_d = acc_next;
        end else begin
            acc_d = acc_q;
        end
    end

    // PE state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/skewed_systolic_mac.sv
// ROWS x COLS output-stationary systolic MAC with internal operand skew and row-wise drain.
// SA_SATURATE_EN (in sa_pe) switches accumulation from wrapping to saturating.
module skewed_systolic_mac
    import sa_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 64,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_signed,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [ROWS*DATA_W-1:0] a_in,
    input  logic [COLS*DATA_W-1:0] b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLS*ACC_W-1:0]  out_data,
    output logic [RW-1:0]          out_row,
    output logic                   out_last,
    output logic                   busy
);

    localparam int FLUSH_LEN = flush_len(ROWS, COLS);
    localparam int CNT_W     = $clog2(FLUSH_LEN + 1);

    sa_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]     row_q, row_d;
    logic              sgn_q, sgn_d;
    logic              fire, clr, en, sgn_eff;

    logic [DATA_W-1:0] a_lane [ROWS];
    logic [DATA_W-1:0] b_lane [COLS];
    logic [DATA_W-1:0] a_into [ROWS][COLS];
    logic [DATA_W-1:0] b_into [ROWS][COLS];
    logic [DATA_W-1:0] a_pass [ROWS][COLS];
    logic [DATA_W-1:0] b_pass [ROWS][COLS];
    logic [ACC_W-1:0]  acc    [ROWS][COLS];

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign fire      = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DRAIN);
    assign out_row   = row_q;
    assign out_last  = out_valid && (row_q == RW'(ROWS - 1));
    // The first beat must use the incoming sign mode; the latched copy is not yet loaded
    assign clr       = (state_q == IDLE) && fire;
    assign en        = (state_q != DRAIN);
    assign sgn_eff   = (state_q == IDLE) ? i_signed : sgn_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_lane[r] = fire ? a_in[r*DATA_W +: DATA_W] : '0;
        end else begin : g_delay
            logic [DATA_W-1:0] sh_q [r];
            logic [DATA_W-1:0] sh_d [r];
            // Row skew line: idle cycles shift zeros so stale data never reaches the array
            always_comb begin
                sh_d[0] = fire ? a_in[r*DATA_W +: DATA_W] : '0;
                for (int k = 1; k < r; k++) sh_d[k] = sh_q[k-1];
            end
            // Row skew registers
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < r; k++) sh_q[k] <= '0;
                end else begin
                    for (int k = 0; k < r; k++) sh_q[k] <= sh_d[k];
                end
            end
            assign a_lane[r] = sh_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign b_lane[c] = fire ? b_in[c*DATA_W +: DATA_W] : '0;
        end else begin : g_delay
            logic [DATA_W-1:0] sh_q [c];
            logic [DATA_W-1:0] sh_d [c];
            // Column skew line
            always_comb begin
                sh_d[0] = fire ? b_in[c*DATA_W +: DATA_W] : '0;
                for (int k = 1; k < c; k++) sh_d[k] = sh_q[k-1];
            end
            // Column skew registers
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < c; k++) sh_q[k] <= '0;
                end else begin
                    for (int k = 0; k < c; k++) sh_q[k] <= sh_d[k];
                end
            end
            assign b_lane[c] = sh_q[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c == 0) begin : g_a_edge
                assign a_into[r][c] = a_lane[r];
            end else begin : g_a_inner
                assign a_into[r][c] = a_pass[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign b_into[r][c] = b_lane[c];
            end else begin : g_b_inner
                assign b_into[r][c] = b_pass[r-1][c];
            end
            sa_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .clr   (clr),
                .sgn   (sgn_eff),
                .a_i   (a_into[r][c]),
                .b_i   (b_into[r][c]),
                .a_o   (a_pass[r][c]),
                .b_o   (b_pass[r][c]),
                .acc_o (acc[r][c])
            );
        end
    end

    // Tile sequencing: collect beats, flush the skew, then drain one row per handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        sgn_d   = sgn_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    sgn_d   = i_signed;
                    cnt_d   = '0;
                    state_d = in_last ? FLUSH : LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (fire && in_last) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else begin
                    state_d = LOAD;
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
                    row_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    row_d = row_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            sgn_q   <= sgn_d;
        end
    end

    // Present the selected accumulator row only while draining
    always_comb begin
        out_data = '0;
        if (state_q == DRAIN) begin
            for (int c = 0; c < COLS; c++) out_data[c*ACC_W +: ACC_W] = acc[row_q][c];
        end else begin
            out_data = '0;
        end
    end

endmodule
